// File: rtl/sb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sb_pkg : shared types and constants for the switchboard bridge     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package sb_pkg;

  typedef enum logic [1:0] {
    SB_MODE_OFF    = 2'd0,
    SB_MODE_ALWAYS = 2'd1,
    SB_MODE_RANDOM = 2'd2
  } sb_mode_e;

  localparam logic [15:0] SB_LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] SB_LFSR_TAPS = 16'hB400;
  localparam int          SB_DEST_W    = 32;

  // Encoding 3 is not an enum member and falls through to "always"
  function automatic logic sb_gate(input logic [1:0] mode, input logic rnd);
    case (sb_mode_e'(mode))
      SB_MODE_OFF:    return 1'b0;
      SB_MODE_RANDOM: return rnd;
      default:        return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_queue_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sb_queue_bridge_if : one ready/valid packet channel                |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface sb_queue_bridge_if
  import sb_pkg::*;
#(
  parameter int DW = 416
);
  logic [DW-1:0]        data;
  logic [SB_DEST_W-1:0] dest;
  logic                 last;
  logic                 valid;
  logic                 ready;

  modport master (output data, dest, last, valid, input ready);
  modport slave  (input data, dest, last, valid, output ready);
endinterface
`default_nettype wire

// File: rtl/sb_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sb_sync_fifo : single-clock FIFO, head reads zero when empty       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [AW:0] C_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + C_ONE;
      if (w_pop)  r_rptr <= r_rptr + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/sb_queue_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sb_queue_bridge : host queues <-> ready/valid link, with throttling|
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module sb_queue_bridge
  import sb_pkg::*;
#(
  parameter int DW                 = 416,
  parameter int DEPTH              = 16,
  parameter int VALID_MODE_DEFAULT = 1,
  parameter int READY_MODE_DEFAULT = 1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  sb_queue_bridge_if.slave  tx_push,
  sb_queue_bridge_if.master tx,
  sb_queue_bridge_if.slave  rx,
  sb_queue_bridge_if.master rx_pop,
  input  wire logic       valid_mode_we,
  input  wire logic       ready_mode_we,
  input  wire logic [1:0] mode_wdata
);
  localparam int PW = DW + SB_DEST_W + 1;

  logic [15:0]   r_lfsr;
  logic [1:0]    r_valid_mode;
  logic [1:0]    r_ready_mode;
  logic          r_hold;

  logic          w_tx_full;
  logic          w_tx_empty;
  logic [PW-1:0] w_tx_head;
  logic          w_tx_valid;
  logic          w_tx_xfer;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [PW-1:0] w_rx_head;
  logic          w_rx_ready;
  logic          w_rx_xfer;
  logic          w_rx_pop;

  assign tx_push.ready = ~w_tx_full;

  // Once offered, a beat stays offered until taken, whatever the mode does
  assign w_tx_valid = ~w_tx_empty & (r_hold | sb_gate(r_valid_mode, r_lfsr[0]));
  assign w_tx_xfer  = w_tx_valid & tx.ready;
  assign tx.valid   = w_tx_valid;
  assign {tx.data, tx.dest, tx.last} = w_tx_head;

  assign w_rx_ready = ~w_rx_full & sb_gate(r_ready_mode, r_lfsr[8]);
  assign w_rx_xfer  = rx.valid & w_rx_ready;
  assign rx.ready   = w_rx_ready;

  assign w_rx_pop     = ~w_rx_empty & rx_pop.ready;
  assign rx_pop.valid = ~w_rx_empty;
  assign {rx_pop.data, rx_pop.dest, rx_pop.last} = w_rx_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr       <= SB_LFSR_SEED;
      r_valid_mode <= 2'(VALID_MODE_DEFAULT);
      r_ready_mode <= 2'(READY_MODE_DEFAULT);
      r_hold       <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & SB_LFSR_TAPS)};
      if (valid_mode_we) r_valid_mode <= mode_wdata;
      if (ready_mode_we) r_ready_mode <= mode_wdata;
      r_hold <= w_tx_valid & ~tx.ready;
    end
  end

  sb_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (tx_push.valid & ~w_tx_full),
    .i_wdata ({tx_push.data, tx_push.dest, tx_push.last}),
    .i_pop   (w_tx_xfer),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  sb_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_xfer),
    .i_wdata ({rx.data, rx.dest, rx.last}),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_sb_queue_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sb_queue_bridge : scoreboard + vector bench for sb_queue_bridge |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_sb_queue_bridge;
  import sb_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
  } pkt_t;

  typedef struct {
    logic [1:0] vmode;
    logic [1:0] rmode;
    logic       exp_tx_valid;
    logic       exp_rx_ready;
  } mode_vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_mode_we;
  logic       ready_mode_we;
  logic [1:0] mode_wdata;

  sb_queue_bridge_if #(.DW(DW)) tp ();
  sb_queue_bridge_if #(.DW(DW)) tx ();
  sb_queue_bridge_if #(.DW(DW)) rx ();
  sb_queue_bridge_if #(.DW(DW)) rp ();

  sb_queue_bridge #(
    .DW                 (DW),
    .DEPTH              (DEPTH),
    .VALID_MODE_DEFAULT (1),
    .READY_MODE_DEFAULT (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_push       (tp),
    .tx            (tx),
    .rx            (rx),
    .rx_pop        (rp),
    .valid_mode_we (valid_mode_we),
    .ready_mode_we (ready_mode_we),
    .mode_wdata    (mode_wdata)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  pkt_t txq[$];
  pkt_t rxq[$];
  bit   tx_stall;
  pkt_t tx_stall_pkt;
  bit   tp_fire, rx_fire;
  int   tx_out, rx_out;
  bit   rnd_phase;
  bit   seen_v1, seen_v0, seen_r1, seen_r0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: outputs are checked before this cycle's pushes are recorded,
  // so an entry pushed into an empty queue can never be taken the same cycle.
  task automatic sample();
    pkt_t cur_tx, cur_rp;
    cur_tx = {tx.data, tx.dest, tx.last};
    cur_rp = {rp.data, rp.dest, rp.last};
    if (rnd_phase) begin
      if (tx.valid) seen_v1 = 1'b1; else if (txq.size() > 0) seen_v0 = 1'b1;
      if (rx.ready) seen_r1 = 1'b1; else if (rxq.size() < DEPTH) seen_r0 = 1'b1;
    end
    if (tx_stall) begin
      check("tx_hold_valid", tx.valid, 1'b1);
      check("tx_hold_payload", cur_tx, tx_stall_pkt);
    end
    if (tx.valid && tx.ready) begin
      check("tx_sb_pending", txq.size() > 0, 1'b1);
      if (txq.size() > 0) check("tx_payload", cur_tx, txq.pop_front());
      tx_out++;
    end
    if (rp.valid && rp.ready) begin
      check("rx_sb_pending", rxq.size() > 0, 1'b1);
      if (rxq.size() > 0) check("rx_payload", cur_rp, rxq.pop_front());
      rx_out++;
    end
    tx_stall     = tx.valid && !tx.ready;
    tx_stall_pkt = cur_tx;
    tp_fire = tp.valid && tp.ready;
    rx_fire = rx.valid && rx.ready;
    if (tp_fire) txq.push_back({tp.data, tp.dest, tp.last});
    if (rx_fire) rxq.push_back({rx.data, rx.dest, rx.last});
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mode(input logic is_valid, input logic [1:0] d);
    valid_mode_we = is_valid;
    ready_mode_we = !is_valid;
    mode_wdata    = d;
    tick();
    valid_mode_we = 1'b0;
    ready_mode_we = 1'b0;
  endtask

  task automatic set_tp(input logic v, input logic [31:0] d, input logic [31:0] dst, input logic l);
    tp.valid = v; tp.data = d; tp.dest = dst; tp.last = l;
  endtask

  task automatic set_rx(input logic v, input logic [31:0] d, input logic [31:0] dst, input logic l);
    rx.valid = v; rx.data = d; rx.dest = dst; rx.last = l;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mode_vec_t mvec [4];
    int        tx_in, rx_in;
    mvec[0] = '{2'd0, 2'd0, 1'b0, 1'b0};
    mvec[1] = '{2'd3, 2'd3, 1'b1, 1'b1};
    mvec[2] = '{2'd0, 2'd1, 1'b1, 1'b1};   // hold keeps the beat offered
    mvec[3] = '{2'd1, 2'd0, 1'b1, 1'b0};

    reset = 1'b1;
    valid_mode_we = 1'b0; ready_mode_we = 1'b0; mode_wdata = 2'd0;
    set_tp(1'b0, 32'd0, 32'd0, 1'b0);
    set_rx(1'b0, 32'd0, 32'd0, 1'b0);
    tx.ready = 1'b0; rp.ready = 1'b0;
    rnd_phase = 1'b0; tx_stall = 1'b0;
    seen_v1 = 0; seen_v0 = 0; seen_r1 = 0; seen_r0 = 0;
    tx_out = 0; rx_out = 0;
    #1 reset = 1'b0;
    #1;
    check("rst_tx_valid", tx.valid, 1'b0);
    check("rst_tx_data", tx.data, 32'd0);
    check("rst_rp_valid", rp.valid, 1'b0);
    check("rst_rp_data", rp.data, 32'd0);
    check("rst_tp_ready", tp.ready, 1'b1);
    check("rst_rx_ready", rx.ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Basic TX: three packets, back to back, through an initially empty queue
    tx.ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_tp(1'b1, 32'(i), 32'd7, i == 3);
      tick();
      check("basic_tx_valid", tx.valid, 1'b1);
      check("basic_tx_data", tx.data, 32'(i));
      check("basic_tx_dest", tx.dest, 32'd7);
      check("basic_tx_last", tx.last, i == 3);
    end
    set_tp(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check("basic_tx_idle_valid", tx.valid, 1'b0);
    check("basic_tx_idle_data", tx.data, 32'd0);

    // Hold stability across back-pressure and a mode write
    tx.ready = 1'b0;
    set_tp(1'b1, 32'h55, 32'h1234, 1'b1);
    tick();
    set_tp(1'b0, 32'd0, 32'd0, 1'b0);
    check("hold_valid_rise", tx.valid, 1'b1);
    repeat (5) tick();
    write_mode(1'b1, 2'd0);
    check("hold_after_mode0_valid", tx.valid, 1'b1);
    check("hold_after_mode0_data", tx.data, 32'h55);
    tick();
    tx.ready = 1'b1;
    tick();
    check("hold_released_valid", tx.valid, 1'b0);
    tx.ready = 1'b0;

    // Mode vector table with one beat parked in the TX queue
    write_mode(1'b1, 2'd0);
    set_tp(1'b1, 32'hA5, 32'd1, 1'b0);
    tick();
    set_tp(1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      write_mode(1'b1, mvec[i].vmode);
      write_mode(1'b0, mvec[i].rmode);
      check($sformatf("mode_vec%0d_tx_valid", i), tx.valid, mvec[i].exp_tx_valid);
      check($sformatf("mode_vec%0d_rx_ready", i), rx.ready, mvec[i].exp_rx_ready);
    end
    write_mode(1'b0, 2'd1);
    tx.ready = 1'b1;
    tick();
    check("mode_vec_drained", tx.valid, 1'b0);
    tx.ready = 1'b0;

    // Fill / drain three times so the pointers wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        check("fill_push_ready", tp.ready, 1'b1);
        set_tp(1'b1, 32'(r * 100 + i), 32'(r), i == DEPTH - 1);
        tick();
      end
      set_tp(1'b0, 32'd0, 32'd0, 1'b0);
      check("fill_full_push_ready", tp.ready, 1'b0);
      tx.ready = 1'b1;
      repeat (DEPTH) tick();
      check("drain_valid", tx.valid, 1'b0);
      check("drain_data", tx.data, 32'd0);
      check("drain_push_ready", tp.ready, 1'b1);
      tx.ready = 1'b0;
    end

    // RX back-pressure
    rp.ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_rx(1'b1, 32'(i), 32'(i + 40), i[0]);
      tick();
      if (i == 0) check("rx_latency_pop_valid", rp.valid, 1'b1);
    end
    check("rx_full_ready", rx.ready, 1'b0);
    set_rx(1'b1, 32'd16, 32'd56, 1'b1);
    tick();
    check("rx_full_ready_held", rx.ready, 1'b0);
    rp.ready = 1'b1;
    tick();
    rp.ready = 1'b0;
    check("rx_ready_after_pop", rx.ready, 1'b1);
    tick();
    set_rx(1'b0, 32'd0, 32'd0, 1'b0);
    check("rx_full_again", rx.ready, 1'b0);
    rp.ready = 1'b1;
    repeat (DEPTH) tick();
    check("rx_drained_valid", rp.valid, 1'b0);
    check("rx_drained_data", rp.data, 32'd0);
    check("rx_drained_sb", rxq.size(), 32'd0);
    rp.ready = 1'b0;

    // Random throttling on both halves
    write_mode(1'b1, 2'd2);
    write_mode(1'b0, 2'd2);
    tx_out = 0; rx_out = 0; tx_in = 0; rx_in = 0;
    rnd_phase = 1'b1;
    set_tp(1'b1, 32'd0, 32'd0, 1'b0);
    set_rx(1'b1, 32'h1000, 32'd0, 1'b0);
    for (int c = 0; c < 6000 && !(tx_out == 200 && rx_out == 200); c++) begin
      tx.ready = 1'($urandom_range(0, 1));
      rp.ready = 1'($urandom_range(0, 1));
      tick();
      if (tp_fire) tx_in++;
      if (rx_fire) rx_in++;
      set_tp(tx_in < 200, 32'(tx_in), 32'(tx_in * 3), (tx_in % 5) == 4);
      set_rx(rx_in < 200, 32'(rx_in + 32'h1000), 32'(rx_in * 7), (rx_in % 3) == 2);
    end
    rnd_phase = 1'b0;
    set_tp(1'b0, 32'd0, 32'd0, 1'b0);
    set_rx(1'b0, 32'd0, 32'd0, 1'b0);
    check("rnd_tx_count", tx_out, 32'd200);
    check("rnd_rx_count", rx_out, 32'd200);
    check("rnd_seen_valid_hi", seen_v1, 1'b1);
    check("rnd_seen_valid_lo", seen_v0, 1'b1);
    check("rnd_seen_ready_hi", seen_r1, 1'b1);
    check("rnd_seen_ready_lo", seen_r0, 1'b1);
    tx.ready = 1'b0; rp.ready = 1'b0;

    // Asynchronous reset with data queued and modes changed
    for (int i = 0; i < 5; i++) begin
      set_tp(1'b1, 32'(i + 32'h300), 32'd9, 1'b0);
      set_rx(1'b1, 32'(i + 32'h200), 32'd8, 1'b1);
      write_mode(1'b0, 2'd1);
    end
    set_tp(1'b0, 32'd0, 32'd0, 1'b0);
    set_rx(1'b0, 32'd0, 32'd0, 1'b0);
    write_mode(1'b1, 2'd0);
    write_mode(1'b0, 2'd0);
    #3 reset = 1'b0;
    #1;
    check("arst_tx_valid", tx.valid, 1'b0);
    check("arst_tx_data", tx.data, 32'd0);
    check("arst_tx_dest", tx.dest, 32'd0);
    check("arst_rp_valid", rp.valid, 1'b0);
    check("arst_rp_data", rp.data, 32'd0);
    check("arst_tp_ready", tp.ready, 1'b1);
    check("arst_rx_ready", rx.ready, 1'b1);
    txq.delete(); rxq.delete(); tx_stall = 1'b0;
    #2 reset = 1'b1;
    tick();
    check("post_rst_tx_valid", tx.valid, 1'b0);
    check("post_rst_rp_valid", rp.valid, 1'b0);
    check("post_rst_rx_ready", rx.ready, 1'b1);
    set_tp(1'b1, 32'h77, 32'd3, 1'b1);
    tick();
    set_tp(1'b0, 32'd0, 32'd0, 1'b0);
    check("post_rst_mode_default", tx.valid, 1'b1);
    tx.ready = 1'b1;
    tick();
    check("post_rst_drained", tx.valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
